// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// The HALTED state exists only when HALT_DETECT_EN is defined.
package fetch_pkg;

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StHold,
    StDrain
`ifdef HALT_DETECT_EN
    ,
    StHalted
`endif
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE       = 5'b00000;
  localparam logic [15:0] PC_INC            = 16'd2;

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller (master)
// and instruction memory (slave).
interface fetch_stage_ctrl_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_busy;
  logic        imem_done;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_busy, imem_done, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_busy, imem_done, imem_rdata
  );
endinterface

// File: rtl/fetch_hold_buf.sv
// Holds one fetched {instr, pc} pair while decode is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [15:0] load_instr,
  input  logic [15:0] load_pc,
  output logic [15:0] instr,
  output logic [15:0] pc
);

  logic [31:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (clear) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= {load_instr, load_pc};
    end
  end

  assign instr = data_q[31:16];
  assign pc    = data_q[15:0];

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Instruction-fetch controller feeding the IF/ID register; owns the PC and the imem bus.
// Optional HALT detection is enabled by defining HALT_DETECT_EN.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_in,
  input  logic                      redirect_valid,
  input  logic [15:0]               redirect_pc,
  fetch_stage_ctrl_if.master        imem,
  output logic                      if_en,
  output logic                      if_valid,
  output logic [15:0]               if_instr,
  output logic [15:0]               if_pc,
  output logic [15:0]               if_pc_plus2,
  output logic                      halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         pc_en;
  logic         hold_load, hold_clear;
  logic [15:0]  hold_instr, hold_pc;
  logic         deliver, accepted;
  logic [15:0]  dlv_instr, dlv_pc;

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_instr (imem.imem_rdata),
    .load_pc    (pc_q),
    .instr      (hold_instr),
    .pc         (hold_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q + PC_INC;
    pc_en      = 1'b0;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    deliver    = 1'b0;
    dlv_instr  = NOP_INSTR;
    dlv_pc     = pc_q;
    accepted   = 1'b0;

    unique case (state_q)
      StReq: begin
        accepted = !imem.imem_busy;
        if (accepted) state_d = StWait;
      end
      StWait: begin
        if (imem.imem_done && !stall_in) begin
          deliver   = 1'b1;
          dlv_instr = imem.imem_rdata;
          pc_en     = 1'b1;
          state_d   = StReq;
        end else if (imem.imem_done) begin
          hold_load = 1'b1;
          state_d   = StHold;
        end
      end
      StHold: begin
        deliver   = 1'b1;
        dlv_instr = hold_instr;
        dlv_pc    = hold_pc;
        if (!stall_in) begin
          pc_en   = 1'b1;
          state_d = StReq;
        end
      end
      StDrain: begin
        if (imem.imem_done) state_d = StReq;
      end
`ifdef HALT_DETECT_EN
      StHalted: state_d = StHalted;
`endif
      default: state_d = StReq;
    endcase

`ifdef HALT_DETECT_EN
    // HALT still reaches IF/ID; fetching stops only after it has been taken.
    if (deliver && !stall_in && is_halt(dlv_instr)) state_d = StHalted;
`endif

    // A redirect overrides everything; an in-flight response must be drained.
    if (redirect_valid) begin
      deliver    = 1'b0;
      dlv_instr  = NOP_INSTR;
      pc_en      = 1'b1;
      pc_d       = redirect_pc;
      hold_load  = 1'b0;
      hold_clear = 1'b1;
      if ((state_q == StReq && accepted) ||
          ((state_q == StWait || state_q == StDrain) && !imem.imem_done)) begin
        state_d = StDrain;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (pc_en) pc_q <= pc_d;
    end
  end

  // Gated by rst so no request escapes while reset is held.
  assign imem.imem_req  = rst && (state_q == StReq);
  assign imem.imem_addr = pc_q;

  assign if_en       = !stall_in;
  assign if_valid    = deliver;
  assign if_instr    = deliver ? dlv_instr : NOP_INSTR;
  assign if_pc       = deliver ? dlv_pc : 16'h0000;
  assign if_pc_plus2 = deliver ? dlv_pc + PC_INC : 16'h0000;

`ifdef HALT_DETECT_EN
  assign halted = (state_q == StHalted);
`else
  assign halted = 1'b0;
`endif

  imem_done_in_window: assert property (@(posedge clk) disable iff (!rst)
    imem.imem_done |-> (state_q == StWait || state_q == StDrain));

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Table-driven bench for fetch_stage_ctrl with a response scoreboard and a latency-modelled memory.
module tb_fetch_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_in;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_en, if_valid, halted;
  logic [15:0] if_instr, if_pc, if_pc_plus2;

  always #5 clk = ~clk;

  fetch_stage_ctrl_if bus ();

  fetch_stage_ctrl #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_en          (if_en),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus2    (if_pc_plus2),
    .halted         (halted)
  );

  typedef struct {
    logic        stall;
    logic        busy;
    logic        redir;
    logic [15:0] rpc;
    int          lat;
    logic        e_req;
    logic        e_valid;
    logic [15:0] e_addr;
    logic        e_halt;
  } vec_t;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          timer    = 0;
  logic [15:0] resp_addr = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0012) return 16'h1234;
    if (a == 16'h0020) return 16'h0000;
    return {4'hA, a[12:1]};
  endfunction

  task automatic add(input int s, input int b, input int r, input logic [15:0] rpc,
                     input int lat, input int req, input int vld, input logic [15:0] addr,
                     input int hlt);
    vec_t v;
    v.stall   = (s != 0);
    v.busy    = (b != 0);
    v.redir   = (r != 0);
    v.rpc     = rpc;
    v.lat     = lat;
    v.e_req   = (req != 0);
    v.e_valid = (vld != 0);
    v.e_addr  = addr;
    v.e_halt  = (hlt != 0);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_req"},    16'(bus.imem_req), 16'h0);
    check({tag, "_if_valid"},    16'(if_valid),     16'h0);
    check({tag, "_if_instr"},    if_instr,          16'h0800);
    check({tag, "_if_pc"},       if_pc,             16'h0000);
    check({tag, "_if_pc_plus2"}, if_pc_plus2,       16'h0000);
    check({tag, "_halted"},      16'(halted),       16'h0);
    check({tag, "_imem_addr"},   bus.imem_addr,     16'h0000);
  endtask

  // Called #1 after a posedge: drive the cycle, then check at the negedge.
  task automatic cycle_body(input vec_t v);
    exp_t        e;
    logic [15:0] p2;
    if (timer > 0) begin
      timer         = timer - 1;
      bus.imem_done = (timer == 0);
    end else begin
      bus.imem_done = 1'b0;
    end
    bus.imem_rdata = bus.imem_done ? mem_word(resp_addr) : 16'h0000;
    stall_in       = v.stall;
    bus.imem_busy  = v.busy;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    @(negedge clk);
    check("imem_req",  16'(bus.imem_req), 16'(v.e_req));
    check("if_valid",  16'(if_valid),     16'(v.e_valid));
    check("imem_addr", bus.imem_addr,     v.e_addr);
    check("halted",    16'(halted),       16'(v.e_halt));
    check("if_en",     16'(if_en),        16'(!v.stall));
    if (!v.e_valid) check("bubble_instr", if_instr, 16'h0800);
    if (if_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 16'(if_valid), 16'h0);
      end else begin
        e  = sb[0];
        p2 = e.pc + 16'd2;
        check("sb_instr",     if_instr,    e.instr);
        check("sb_pc",        if_pc,       e.pc);
        check("sb_pc_plus2",  if_pc_plus2, p2);
        if (!v.stall) void'(sb.pop_front());
      end
    end
    if (v.e_req && !v.busy) begin
      sb.push_back('{instr: mem_word(v.e_addr), pc: v.e_addr});
      timer     = v.lat;
      resp_addr = v.e_addr;
    end
    if (v.redir) sb.delete();
  endtask

  initial begin
    rst            = 1'b0;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    bus.imem_busy  = 1'b0;
    bus.imem_done  = 1'b0;
    bus.imem_rdata = 16'h0000;

    // stall busy redir rpc lat | req valid addr halted
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0);  // 0  reset release, fetch 0000
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0002, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0002, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0004, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0004, 0);
    add(0, 1, 1, 16'h0010, 1, 1, 0, 16'h0006, 0);  // 6  redirect in REQ, not accepted
    add(0, 1, 0, 16'h0000, 1, 1, 0, 16'h0010, 0);  // 7-9 busy, addr held
    add(0, 1, 0, 16'h0000, 1, 1, 0, 16'h0010, 0);
    add(0, 1, 0, 16'h0000, 1, 1, 0, 16'h0010, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0010, 0);  // 10 single accept
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0010, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0012, 0);  // 12 fetch 1234
    add(1, 0, 0, 16'h0000, 1, 0, 0, 16'h0012, 0);  // 13 done under stall -> HOLD
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0012, 0);
    add(1, 0, 0, 16'h0000, 1, 0, 1, 16'h0012, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0012, 0);  // 16 stall drops
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0014, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0014, 0);
    add(0, 0, 0, 16'h0000, 3, 1, 0, 16'h0016, 0);  // 19 slow memory
    add(0, 0, 1, 16'h0100, 1, 0, 0, 16'h0016, 0);  // 20 redirect in WAIT -> DRAIN
    add(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0100, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0100, 0);  // 22 late done discarded
    add(0, 0, 0, 16'h0000, 3, 1, 0, 16'h0100, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0100, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0100, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0100, 0);
    add(0, 1, 1, 16'hFFFE, 1, 1, 0, 16'h0102, 0);  // 27 redirect to FFFE
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'hFFFE, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'hFFFE, 0);  // 29 pc_plus2 wraps
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0);
    add(0, 1, 1, 16'h0020, 1, 1, 0, 16'h0002, 0);  // 32 redirect to HALT word
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0020, 0);
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0020, 0);  // 34 HALT delivered
`ifdef HALT_DETECT_EN
    add(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0022, 1);
    add(0, 0, 1, 16'h0040, 1, 0, 0, 16'h0022, 1);
`else
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0022, 0);
    add(0, 0, 1, 16'h0040, 1, 0, 0, 16'h0022, 0);
`endif
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0040, 0);  // 37 resumed
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0040, 0);
    add(0, 0, 0, 16'h0000, 3, 1, 0, 16'h0042, 0);  // 39 slow fetch, reset hits mid-WAIT
    add(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0042, 0);
    add(0, 0, 0, 16'h0000, 1, 1, 0, 16'h0000, 0);  // 41 after reset release
    add(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 0);

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");

    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle_body(vecs[0]);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      cycle_body(vecs[i]);
    end

    // Async reset mid-cycle while a response is still outstanding.
    @(posedge clk);
    #1;
    stall_in       = 1'b0;
    redirect_valid = 1'b0;
    bus.imem_busy  = 1'b0;
    bus.imem_done  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    timer = 0;
    sb.delete();
    bus.imem_done  = 1'b1;
    bus.imem_rdata = 16'hBEEF;
    @(posedge clk);
    #1;
    check_reset_outputs("stray_done");
    bus.imem_done = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle_body(vecs[41]);
    @(posedge clk);
    #1;
    cycle_body(vecs[42]);
    check("sb_drained", 16'(sb.size()), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
